tc_host: RTL and testbench

TC_HOST -- requirements
Module: tc_host

---
 rtl/tc_host.sv | 134 +++++++++++++
 tb/tb_tc_host.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_host.sv
// Host-command to timer-bus bridge with interrupt flag service (read TIFR, write-1-to-clear).
// Writes take 1 bus cycle; reads answer RD_LAT+1 cycles after the strobe; cmd_ready drops while busy or while an IRQ is pending.
module tc_host #(
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  TIFR_ADDR = 8'h15,
  parameter logic [7:0]  IRQ_MASK  = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  output logic       read,
  output logic       write,
  input  logic [7:0] rdata,
  input  logic       interrupt_request,
  output logic [7:0] irq_count,
  output logic [7:0] irq_flags
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_WAIT  = 3'd3,
    IRQ_RD   = 3'd4,
    IRQ_WAIT = 3'd5,
    IRQ_WR   = 3'd6
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  logic       wait_done;
  logic       accept;
  logic       irq_take;
  logic [7:0] irq_f;

  assign irq_f     = rdata & IRQ_MASK;
  assign wait_done = (wait_cnt == 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    accept    = 1'b0;
    irq_take  = 1'b0;
    case (state)
      IDLE: begin
        // A pending interrupt blocks command acceptance entirely.
        if (interrupt_request) begin
          irq_take  = 1'b1;
          state_nxt = IRQ_RD;
        end else begin
          cmd_ready = rst;
          if (cmd_valid && rst) begin
            accept    = 1'b1;
            state_nxt = cmd_write ? WR : RD;
          end
        end
      end
      WR: begin
        write     = 1'b1;
        state_nxt = IDLE;
      end
      RD: begin
        read      = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_done) state_nxt = IDLE;
      end
      IRQ_RD: begin
        read      = 1'b1;
        state_nxt = IRQ_WAIT;
      end
      IRQ_WAIT: begin
        if (wait_done) state_nxt = (irq_f != 8'h00) ? IRQ_WR : IDLE;
      end
      IRQ_WR: begin
        write     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 3'd0;
      addr      <= 8'h00;
      wdata     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      irq_count <= 8'h00;
      irq_flags <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        addr <= cmd_addr;
        if (cmd_write) wdata <= cmd_wdata;
      end
      if (irq_take) addr <= TIFR_ADDR;

      if (state == RD || state == IRQ_RD) wait_cnt <= WAIT_INIT;
      else if (!wait_done)                wait_cnt <= wait_cnt - 3'd1;

      if (state == RD_WAIT && wait_done) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rdata;
      end
      // wdata carries the captured flags into IRQ_WR and on into irq_flags.
      if (state == IRQ_WAIT && wait_done && irq_f != 8'h00) wdata <= irq_f;
      if (state == IRQ_WR) begin
        irq_flags <= wdata;
        if (irq_count != 8'hFF) irq_count <= irq_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tc_host.sv
// Directed bench for tc_host: timer model returns rd_val only in the cycle RD_LAT after a read strobe.
module tb_tc_host;
  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       read;
  logic       write;
  logic [7:0] rdata;
  logic       interrupt_request = 1'b0;
  logic [7:0] irq_count;
  logic [7:0] irq_flags;

  logic [7:0] rd_val = 8'h00;
  logic [7:0] rd_hist = 8'h00;

  int checks = 0;
  int passes = 0;
  int n_wr = 0, n_rd = 0, n_rsp = 0, n_both = 0;

  tc_host #(.RD_LAT(LAT), .TIFR_ADDR(8'h15), .IRQ_MASK(8'h07)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .addr(addr), .wdata(wdata), .read(read), .write(write), .rdata(rdata),
    .interrupt_request(interrupt_request),
    .irq_count(irq_count), .irq_flags(irq_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_hist <= {rd_hist[6:0], read};
  assign rdata = rd_hist[LAT-1] ? rd_val : 8'hEE;

  always @(negedge clk) begin
    if (write) n_wr++;
    if (read) n_rd++;
    if (rsp_valid) n_rsp++;
    if (read && write) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data: got %h want 00", rsp_data); else passes++;
    checks++; if ({addr, wdata} !== 16'h0000) $display("FAIL rst_addr_wdata: got %h want 0000", {addr, wdata}); else passes++;
    checks++; if ({read, write} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {read, write}); else passes++;
    checks++; if ({irq_count, irq_flags} !== 16'h0000) $display("FAIL rst_irq_regs: got %h want 0000", {irq_count, irq_flags}); else passes++;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_write();
    int wr0, rsp0;
    tick();
    wr0 = n_wr; rsp0 = n_rsp;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h25; cmd_wdata = 8'h03;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", cmd_ready); else passes++;
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if ({write, read} !== 2'b10) $display("FAIL wr_strobe: got %b want 10", {write, read}); else passes++;
    checks++; if ({addr, wdata} !== 16'h2503) $display("FAIL wr_bus: got %h want 2503", {addr, wdata}); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL wr_busy: got %b want 0", cmd_ready); else passes++;
    tick();
    #1;
    checks++; if ({write, cmd_ready} !== 2'b01) $display("FAIL wr_done: got %b want 01", {write, cmd_ready}); else passes++;
    checks++; if ({addr, wdata} !== 16'h2503) $display("FAIL wr_hold: got %h want 2503", {addr, wdata}); else passes++;
    tick(); tick();
    checks++; if (n_wr - wr0 !== 1) $display("FAIL wr_count: got %0d want 1", n_wr - wr0); else passes++;
    checks++; if (n_rsp !== rsp0) $display("FAIL wr_no_rsp: got %0d want %0d", n_rsp, rsp0); else passes++;
  endtask

  task automatic test_read();
    int rd0;
    tick();
    rd0 = n_rd;
    rd_val = 8'h18;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h27;
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if ({read, write} !== 2'b10) $display("FAIL rd_strobe: got %b want 10", {read, write}); else passes++;
    checks++; if (addr !== 8'h27) $display("FAIL rd_addr: got %h want 27", addr); else passes++;
    tick();
    #1;
    checks++; if ({read, rsp_valid} !== 2'b00) $display("FAIL rd_wait: got %b want 00", {read, rsp_valid}); else passes++;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); else passes++;
    checks++; if (rsp_data !== 8'h18) $display("FAIL rd_rsp_data: got %h want 18", rsp_data); else passes++;
    tick();
    #1;
    checks++; if ({rsp_valid, rsp_data} !== 9'h018) $display("FAIL rd_rsp_hold: got %h want 018", {rsp_valid, rsp_data}); else passes++;
    checks++; if (n_rd - rd0 !== 1) $display("FAIL rd_count: got %0d want 1", n_rd - rd0); else passes++;
  endtask

  task automatic test_irq();
    int rsp0;
    tick();
    rsp0 = n_rsp;
    rd_val = 8'h06;
    interrupt_request = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL irq_ready_idle: got %b want 0", cmd_ready); else passes++;
    tick();
    interrupt_request = 1'b0;
    #1;
    checks++; if ({read, addr, cmd_ready} !== 10'b1_0001_0101_0) $display("FAIL irq_read: got %b want 1000101010", {read, addr, cmd_ready}); else passes++;
    tick();
    #1;
    checks++; if ({read, write, cmd_ready} !== 3'b000) $display("FAIL irq_wait: got %b want 000", {read, write, cmd_ready}); else passes++;
    tick();
    #1;
    checks++; if ({write, cmd_ready} !== 2'b10) $display("FAIL irq_wr_strobe: got %b want 10", {write, cmd_ready}); else passes++;
    checks++; if ({addr, wdata} !== 16'h1506) $display("FAIL irq_wr_bus: got %h want 1506", {addr, wdata}); else passes++;
    tick();
    #1;
    checks++; if ({irq_count, irq_flags} !== 16'h0106) $display("FAIL irq_regs: got %h want 0106", {irq_count, irq_flags}); else passes++;
    checks++; if ({write, cmd_ready} !== 2'b01) $display("FAIL irq_done: got %b want 01", {write, cmd_ready}); else passes++;
    checks++; if (n_rsp !== rsp0) $display("FAIL irq_no_rsp: got %0d want %0d", n_rsp, rsp0); else passes++;
  endtask

  task automatic test_spurious();
    int wr0;
    tick();
    wr0 = n_wr;
    rd_val = 8'hF8;
    interrupt_request = 1'b1;
    tick();
    interrupt_request = 1'b0;
    #1;
    checks++; if (read !== 1'b1) $display("FAIL spur_read: got %b want 1", read); else passes++;
    tick(); tick();
    #1;
    checks++; if ({write, cmd_ready} !== 2'b01) $display("FAIL spur_idle: got %b want 01", {write, cmd_ready}); else passes++;
    checks++; if (n_wr !== wr0) $display("FAIL spur_no_write: got %0d want %0d", n_wr, wr0); else passes++;
    checks++; if ({irq_count, irq_flags} !== 16'h0106) $display("FAIL spur_regs: got %h want 0106", {irq_count, irq_flags}); else passes++;
  endtask

  task automatic test_mask();
    tick();
    rd_val = 8'hFD;
    interrupt_request = 1'b1;
    tick();
    interrupt_request = 1'b0;
    tick(); tick();
    #1;
    checks++; if ({write, wdata} !== 9'h105) $display("FAIL mask_wr: got %h want 105", {write, wdata}); else passes++;
    tick();
    #1;
    checks++; if ({irq_count, irq_flags} !== 16'h0205) $display("FAIL mask_regs: got %h want 0205", {irq_count, irq_flags}); else passes++;
  endtask

  task automatic test_priority();
    tick();
    rd_val = 8'h01;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'hA5;
    interrupt_request = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL prio_ready: got %b want 0", cmd_ready); else passes++;
    tick();
    interrupt_request = 1'b0;
    #1;
    checks++; if ({read, addr} !== 9'h115) $display("FAIL prio_irq_first: got %h want 115", {read, addr}); else passes++;
    tick(); tick();
    #1;
    checks++; if ({write, addr, wdata} !== 17'h11501) $display("FAIL prio_irq_wr: got %h want 11501", {write, addr, wdata}); else passes++;
    tick();
    #1;
    checks++; if ({cmd_ready, irq_count} !== 9'h103) $display("FAIL prio_accept: got %h want 103", {cmd_ready, irq_count}); else passes++;
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if ({write, addr, wdata} !== 17'h140A5) $display("FAIL prio_cmd_wr: got %h want 140a5", {write, addr, wdata}); else passes++;
  endtask

  task automatic test_saturate();
    int wr0;
    int rdy_seen;
    tick();
    wr0 = n_wr;
    rdy_seen = 0;
    rd_val = 8'h01;
    interrupt_request = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      #1;
      if (cmd_ready) rdy_seen++;
      tick();
    end
    interrupt_request = 1'b0;
    #1;
    checks++; if (n_wr - wr0 !== 275) $display("FAIL sat_services: got %0d want 275", n_wr - wr0); else passes++;
    checks++; if (rdy_seen !== 0) $display("FAIL sat_ready_low: got %0d want 0", rdy_seen); else passes++;
    checks++; if ({irq_count, irq_flags} !== 16'hFF01) $display("FAIL sat_count: got %h want ff01", {irq_count, irq_flags}); else passes++;
    tick();
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL sat_idle: got %b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_reset_mid();
    int rsp0, rd0;
    tick();
    rd_val = 8'h77;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33;
    tick();
    cmd_valid = 1'b0;
    tick();
    #1;
    rst = 1'b0;
    #1;
    checks++; if ({addr, wdata, read, write} !== 18'h0) $display("FAIL mid_bus: got %h want 0", {addr, wdata, read, write}); else passes++;
    checks++; if ({rsp_valid, rsp_data} !== 9'h000) $display("FAIL mid_rsp: got %h want 000", {rsp_valid, rsp_data}); else passes++;
    checks++; if ({irq_count, irq_flags, cmd_ready} !== 17'h0) $display("FAIL mid_irq: got %h want 0", {irq_count, irq_flags, cmd_ready}); else passes++;
    tick();
    rst = 1'b1;
    rsp0 = n_rsp; rd0 = n_rd;
    tick(); tick(); tick();
    #1;
    checks++; if (n_rsp !== rsp0) $display("FAIL mid_no_rsp: got %0d want %0d", n_rsp, rsp0); else passes++;
    checks++; if (n_rd !== rd0) $display("FAIL mid_no_strobe: got %0d want %0d", n_rd, rd0); else passes++;
    checks++; if ({cmd_ready, rsp_data} !== 9'h100) $display("FAIL mid_idle: got %h want 100", {cmd_ready, rsp_data}); else passes++;
    checks++; if (n_both !== 0) $display("FAIL rd_wr_overlap: got %0d want 0", n_both); else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_irq();
    test_spurious();
    test_mask();
    test_priority();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
